// File: rtl/ad_burst_writer.sv
// ad_burst_writer: write-side feeder for the DDR2 burst wrapper (mem_clk domain).
// Packs pairs of AD samples into memory words, buffers them in a FIFO and issues
// fixed-length burst writes at consecutive addresses inside a circular region.
//
// Ports:
//   mem_clk, rst          clock, synchronous active-high reset
//   enable                capture enable (0 discards samples and any partial word)
//   ad_data, ad_valid     incoming AD sample stream
//   wr_burst_req/len/addr burst write request to the wrapper
//   wr_burst_data_req     wrapper pulls one word per asserted cycle
//   wr_burst_data         registered write word (one-cycle latency after data_req)
//   wr_burst_finish       wrapper burst-done indication
//   wr_ptr                address one past the last committed word
//   region_wrap           one-cycle pulse when the burst address wraps to BASE_ADDR
//   fifo_level            current FIFO word count
//   overflow, underflow   sticky error flags, cleared on a rising edge of enable
module ad_burst_writer #(
    parameter int unsigned MEM_DATA_BITS = 32,
    parameter int unsigned SAMPLE_BITS   = 16,
    parameter int unsigned ADDR_BITS     = 25,
    parameter int unsigned FIFO_AW       = 9,
    parameter int unsigned BURST_LEN     = 128,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned REGION_WORDS  = 65536
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [SAMPLE_BITS-1:0]   ad_data,
    input  logic                     ad_valid,
    output logic                     wr_burst_req,
    output logic [9:0]               wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic                     wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_finish,
    output logic [ADDR_BITS-1:0]     wr_ptr,
    output logic                     region_wrap,
    output logic [FIFO_AW:0]         fifo_level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_NEXT} state_t;

    // ---------------- sample packer ----------------
    logic                     r_half;
    logic [SAMPLE_BITS-1:0]   r_lo;
    logic                     r_push;
    logic [MEM_DATA_BITS-1:0] r_push_word;
    logic                     r_en_d;
    logic                     w_en_rise;

    assign w_en_rise = enable && !r_en_d;

    // Low sample first; the completed word is handed to the FIFO one cycle later.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            r_half      <= 1'b0;
            r_lo        <= '0;
            r_push      <= 1'b0;
            r_push_word <= '0;
            r_en_d      <= 1'b0;
        end else begin
            r_en_d <= enable;
            r_push <= 1'b0;
            if (!enable) begin
                r_half <= 1'b0;
            end else if (ad_valid) begin
                if (r_half) begin
                    r_push_word <= {ad_data, r_lo};
                    r_push      <= 1'b1;
                    r_half      <= 1'b0;
                end else begin
                    r_lo   <= ad_data;
                    r_half <= 1'b1;
                end
            end
        end
    end

    // ---------------- word FIFO ----------------
    logic [MEM_DATA_BITS-1:0] r_mem [DEPTH];
    logic [FIFO_AW-1:0]       r_wa;
    logic [FIFO_AW-1:0]       r_ra;
    logic [FIFO_AW:0]         r_level;
    logic [MEM_DATA_BITS-1:0] r_data;
    logic                     r_ovf;
    logic                     r_udf;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;

    assign w_full  = (r_level == (FIFO_AW + 1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = r_push && !w_full;
    assign w_pop   = wr_burst_data_req && !w_empty;

    // Storage array: no reset, contents are qualified by the pointers.
    always_ff @(posedge mem_clk) begin
        if (w_push) begin
            r_mem[r_wa] <= r_push_word;
        end
    end

    // Pointers, level, registered read data and sticky flags (a set wins over a clear).
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            r_wa    <= '0;
            r_ra    <= '0;
            r_level <= '0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wa <= r_wa + 1'b1;
            end
            if (w_pop) begin
                r_ra   <= r_ra + 1'b1;
                r_data <= r_mem[r_ra];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (r_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_en_rise) begin
                r_ovf <= 1'b0;
            end
            if (wr_burst_data_req && w_empty) begin
                r_udf <= 1'b1;
            end else if (w_en_rise) begin
                r_udf <= 1'b0;
            end
        end
    end

    // ---------------- burst sequencer ----------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_now;
    logic                  r_req;
    logic                  w_req_nxt;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [ADDR_BITS-1:0]  w_addr_nxt;
    logic [ADDR_BITS-1:0]  w_addr_inc;
    logic [ADDR_BITS-1:0]  r_ptr;
    logic [ADDR_BITS-1:0]  w_ptr_nxt;
    logic                  r_wrap;
    logic                  w_wrap_nxt;

    // Count including a data request arriving this cycle, so a finish that
    // coincides with the last word is still honoured.
    assign w_cnt_now  = r_cnt + CNT_W'(wr_burst_data_req);
    assign w_addr_inc = r_addr + ADDR_BITS'(BURST_LEN);

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_addr  <= ADDR_BITS'(BASE_ADDR);
            r_ptr   <= ADDR_BITS'(BASE_ADDR);
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Finish is only meaningful in DATA with a full count; the wrapper may hold it high while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_ptr_nxt   = r_ptr;
        w_wrap_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level >= (FIFO_AW + 1)'(BURST_LEN)) begin
                    w_state_nxt = S_REQ;
                    w_req_nxt   = 1'b1;
                end
            end
            S_REQ: begin
                if (wr_burst_data_req) begin
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (wr_burst_data_req) begin
                    w_cnt_nxt = w_cnt_now;
                end
                if (wr_burst_finish && (w_cnt_now == CNT_W'(BURST_LEN))) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_state_nxt = S_IDLE;
                if (w_addr_inc == ADDR_BITS'(BASE_ADDR + REGION_WORDS)) begin
                    w_addr_nxt = ADDR_BITS'(BASE_ADDR);
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_addr_nxt = w_addr_inc;
                end
                w_ptr_nxt = w_addr_nxt;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign wr_burst_req  = r_req;
    assign wr_burst_len  = 10'(BURST_LEN);
    assign wr_burst_addr = r_addr;
    assign wr_burst_data = r_data;
    assign wr_ptr        = r_ptr;
    assign region_wrap   = r_wrap;
    assign fifo_level    = r_level;
    assign overflow      = r_ovf;
    assign underflow     = r_udf;

endmodule

// File: tb/tb_ad_burst_writer.sv
// Testbench for ad_burst_writer: two instances (full-size region and a 256-word
// region) share one stimulus stream; a queue-based reference model predicts
// the words, addresses, pointers and flags.
module tb_ad_burst_writer;

    localparam int unsigned BL = 128;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] ad_data;
    logic        ad_valid;
    logic        dreq;
    logic        fin;

    logic        req_a, req_b;
    logic [9:0]  len_a, len_b;
    logic [24:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [24:0] ptr_a, ptr_b;
    logic        wrap_a, wrap_b;
    logic [9:0]  lvl_a, lvl_b;
    logic        ov_a, ov_b;
    logic        un_a, un_b;

    ad_burst_writer dut (
        .mem_clk(clk), .rst(rst), .enable(enable), .ad_data(ad_data), .ad_valid(ad_valid),
        .wr_burst_req(req_a), .wr_burst_len(len_a), .wr_burst_addr(addr_a),
        .wr_burst_data_req(dreq), .wr_burst_data(data_a), .wr_burst_finish(fin),
        .wr_ptr(ptr_a), .region_wrap(wrap_a), .fifo_level(lvl_a),
        .overflow(ov_a), .underflow(un_a)
    );

    ad_burst_writer #(.REGION_WORDS(256)) dut_w (
        .mem_clk(clk), .rst(rst), .enable(enable), .ad_data(ad_data), .ad_valid(ad_valid),
        .wr_burst_req(req_b), .wr_burst_len(len_b), .wr_burst_addr(addr_b),
        .wr_burst_data_req(dreq), .wr_burst_data(data_b), .wr_burst_finish(fin),
        .wr_ptr(ptr_b), .region_wrap(wrap_b), .fifo_level(lvl_b),
        .overflow(ov_b), .underflow(un_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bookkeeping
    int n_chk  = 0;
    int n_fail = 0;

    // reference model
    logic [31:0] q[$];
    logic        m_half, m_ov, m_un, m_prev_en;
    logic [15:0] m_lo;
    int          n_words;
    int          k;

    // wrapper agent
    int          ag_ph, ag_cnt;
    bit          ag_en, gaps, hold_fin, spur, spur_done, spur_chk, poke;
    bit          pend;
    logic [31:0] exp_word;
    logic [31:0] first2 [2];
    int          n_seen;
    int          wraps_a, wraps_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] exp_addr(input int kk, input int region);
        return 25'((kk * BL) % region);
    endfunction

    task automatic m_push(input logic [31:0] w);
        n_words++;
        if (q.size() < 512) q.push_back(w);
        else m_ov = 1'b1;
    endtask

    task automatic observe();
        if (pend) begin
            check("wr_data_a", 64'(data_a), 64'(exp_word));
            check("wr_data_b", 64'(data_b), 64'(exp_word));
            if (n_seen < 2) first2[n_seen] = data_a;
            n_seen++;
            pend = 1'b0;
        end
        if (wrap_a === 1'b1) wraps_a++;
        if (wrap_b === 1'b1) wraps_b++;
    endtask

    task automatic agent();
        logic dq;
        logic fn;
        dq = 1'b0;
        fn = hold_fin;
        case (ag_ph)
            0: begin
                if (poke) begin
                    dq = 1'b1;
                end else if (ag_en && req_a === 1'b1) begin
                    check("burst_addr_a", 64'(addr_a), 64'(exp_addr(k, 65536)));
                    check("burst_addr_b", 64'(addr_b), 64'(exp_addr(k, 256)));
                    check("burst_ptr_a", 64'(ptr_a), 64'(exp_addr(k, 65536)));
                    check("burst_ptr_b", 64'(ptr_b), 64'(exp_addr(k, 256)));
                    check("burst_len", 64'(len_a), 64'(BL));
                    check("burst_req_b", 64'(req_b), 64'd1);
                    ag_ph  = 1;
                    ag_cnt = 0;
                end
            end
            2: ag_ph = 0;
            default: ;
        endcase
        if (ag_ph == 1) begin
            fn = 1'b0;
            if (ag_cnt < int'(BL)) begin
                dq = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (spur && !spur_done && ag_cnt == 100) begin
                    fn = 1'b1;
                    spur_done = 1'b1;
                end
                if (spur && spur_done && !spur_chk && ag_cnt >= 110) begin
                    check("spur_ptr_hold", 64'(ptr_a), 64'(exp_addr(k, 65536)));
                    check("spur_req_low", 64'(req_a), 64'd0);
                    spur_chk = 1'b1;
                end
                if (dq) ag_cnt++;
            end else begin
                fn    = 1'b1;
                ag_ph = 2;
                k++;
            end
        end
        if (dq) begin
            if (q.size() > 0) begin
                exp_word = q.pop_front();
                pend     = 1'b1;
            end else begin
                m_un = 1'b1;
            end
        end
        dreq = dq;
        fin  = fn;
    endtask

    // One clock: check last edge's results, drive the next inputs, advance.
    task automatic cycle(input bit v, input logic [15:0] d);
        observe();
        ad_valid = v;
        ad_data  = d;
        if (enable) begin
            if (!m_prev_en) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
            if (v) begin
                if (m_half) begin
                    m_push({d, m_lo});
                    m_half = 1'b0;
                end else begin
                    m_lo   = d;
                    m_half = 1'b1;
                end
            end
        end else begin
            m_half = 1'b0;
        end
        m_prev_en = enable;
        agent();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        observe();
        rst = 1'b1; ad_valid = 1'b0; dreq = 1'b0; fin = 1'b0;
        q.delete();
        m_half = 1'b0; m_ov = 1'b0; m_un = 1'b0; m_prev_en = 1'b0;
        k = 0; ag_ph = 0; ag_cnt = 0; pend = 1'b0; n_seen = 0; n_words = 0;
        wraps_a = 0; wraps_b = 0; spur_done = 1'b0; spur_chk = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 4000 && !(ag_ph == 0 && q.size() < BL)) begin
            cycle(1'b0, 16'h0);
            n++;
        end
        check("drain_timeout", 64'(n < 4000), 64'd1);
        repeat (4) cycle(1'b0, 16'h0);
    endtask

    task automatic check_quiet(input string t);
        check({t, "_level_a"}, 64'(lvl_a), 64'(q.size()));
        check({t, "_level_b"}, 64'(lvl_b), 64'(q.size()));
        check({t, "_ovf"}, 64'(ov_a), 64'(m_ov));
        check({t, "_udf"}, 64'(un_a), 64'(m_un));
        check({t, "_ptr_a"}, 64'(ptr_a), 64'(exp_addr(k, 65536)));
        check({t, "_ptr_b"}, 64'(ptr_b), 64'(exp_addr(k, 256)));
        check({t, "_addr_a"}, 64'(addr_a), 64'(exp_addr(k, 65536)));
        check({t, "_req"}, 64'(req_a), 64'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; ad_valid = 1'b0; ad_data = '0; dreq = 1'b0; fin = 1'b0;
        ag_en = 1'b1; gaps = 1'b0; hold_fin = 1'b0; spur = 1'b0; poke = 1'b0;
        @(negedge clk);
        do_reset();

        // reset values
        check("rst_req", 64'(req_a), 64'd0);
        check("rst_data", 64'(data_a), 64'd0);
        check("rst_level", 64'(lvl_a), 64'd0);
        check("rst_ovf", 64'(ov_a), 64'd0);
        check("rst_udf", 64'(un_a), 64'd0);
        check("rst_wrap", 64'(wrap_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_ptr", 64'(ptr_a), 64'd0);
        check("rst_len", 64'(len_a), 64'(BL));

        // continuous ramp, two bursts
        enable = 1'b1;
        for (int i = 0; i < 512; i++) cycle(1'b1, 16'(i));
        drain();
        check("t1_word0", 64'(first2[0]), 64'h0001_0000);
        check("t1_word1", 64'(first2[1]), 64'h0003_0002);
        check("t1_ptr", 64'(ptr_a), 64'd256);
        check("t1_wraps_a", 64'(wraps_a), 64'd0);
        check("t1_wraps_b", 64'(wraps_b), 64'd1);
        check_quiet("t1");

        // finish held high while idle plus a spurious mid-burst finish
        do_reset();
        hold_fin = 1'b1; spur = 1'b1; enable = 1'b1;
        while (n_words < 256) cycle($urandom_range(0, 3) != 0, 16'($urandom));
        drain();
        check("t2_spur_seen", 64'(spur_chk), 64'd1);
        check_quiet("t2");
        hold_fin = 1'b0; spur = 1'b0;

        // region wrap with a gappy wrapper
        do_reset();
        gaps = 1'b1; enable = 1'b1;
        while (n_words < 512) cycle($urandom_range(0, 3) != 0, 16'($urandom));
        drain();
        check("t3_wraps_b", 64'(wraps_b), 64'd2);
        check("t3_ptr_b", 64'(ptr_b), 64'd0);
        check("t3_ptr_a", 64'(ptr_a), 64'd512);
        check_quiet("t3");
        gaps = 1'b0;

        // stalled wrapper: FIFO saturates, overflow, then drain
        do_reset();
        ag_en = 1'b0; enable = 1'b1;
        for (int i = 0; i < 1200; i++) cycle(1'b1, 16'($urandom));
        repeat (4) cycle(1'b0, 16'h0);
        check("t4_level", 64'(lvl_a), 64'd512);
        check("t4_level_model", 64'(lvl_a), 64'(q.size()));
        check("t4_ovf", 64'(ov_a), 64'd1);
        check("t4_ovf_b", 64'(ov_b), 64'd1);
        enable = 1'b0; cycle(1'b0, 16'h0);
        enable = 1'b1; cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        check("t4_ovf_clr", 64'(ov_a), 64'd0);
        ag_en = 1'b1;
        drain();
        check_quiet("t4");
        begin
            logic [31:0] last;
            last = data_a;
            poke = 1'b1; cycle(1'b0, 16'h0);
            poke = 1'b0; cycle(1'b0, 16'h0);
            check("t4_udf", 64'(un_a), 64'd1);
            check("t4_udf_hold", 64'(data_a), 64'(last));
        end
        enable = 1'b0; cycle(1'b0, 16'h0);
        enable = 1'b1; cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        check("t4_udf_clr", 64'(un_a), 64'd0);

        // odd sample discarded by enable drop; leftover word stays buffered
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i));
        enable = 1'b0; cycle(1'b0, 16'h0);
        enable = 1'b1;
        for (int i = 3; i < 259; i++) cycle(1'b1, 16'(i));
        drain();
        check("t5_word0", 64'(first2[0]), 64'h0001_0000);
        check("t5_word1", 64'(first2[1]), 64'h0004_0003);
        check("t5_leftover", 64'(lvl_a), 64'd1);
        check_quiet("t5");

        // reset in the middle of a burst
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 256; i++) cycle(1'b1, 16'(i + 1000));
        begin
            int n;
            n = 0;
            while (n < 1000 && !(ag_ph == 1 && ag_cnt >= 50)) begin
                cycle(1'b0, 16'h0);
                n++;
            end
            check("t6_reach50", 64'(n < 1000), 64'd1);
        end
        do_reset();
        check("t6_req", 64'(req_a), 64'd0);
        check("t6_level", 64'(lvl_a), 64'd0);
        check("t6_addr_a", 64'(addr_a), 64'd0);
        check("t6_addr_b", 64'(addr_b), 64'd0);
        enable = 1'b1;
        for (int i = 0; i < 256; i++) cycle(1'b1, 16'($urandom));
        drain();
        check("t6_bursts", 64'(k), 64'(ptr_a / BL));
        check_quiet("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
        $fatal(1, "timeout");
    end

endmodule
